// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - frame-buffer burst reader streaming RGB565 pixels to the VGA output controller
module vga_frame_reader #(
  parameter int                ADDR_W       = 32,
  parameter int                FRAME_PIXELS = 307200,
  parameter int                BURST_LEN    = 16,
  parameter int                FIFO_DEPTH   = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR_0  = '0,
  parameter logic [ADDR_W-1:0] BASE_ADDR_1  = ADDR_W'(32'h0009_6000)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              frame_hold,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [4:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [15:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_start,
  output logic              st_end,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_buf,
  output logic              underrun
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ABORT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_fs_s1, r_fs_s2, r_fs_d;
  logic              r_fh_s1, r_fh_s2, r_fh_d;
  logic              r_fs_pend;
  logic              r_cmd_pend;
  logic              r_front_buf;
  logic              r_swap_ack;
  logic              r_underrun;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_ret_cnt;
  logic [CNT_W-1:0]  r_out_cnt;

  logic [15:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_fifo_cnt;

  logic              w_fs_rise;
  logic              w_fh_rise;
  logic              w_start;
  logic              w_active;
  logic [CNT_W-1:0]  w_outstanding;
  logic [CNT_W-1:0]  w_remain;
  logic [CNT_W-1:0]  w_issue_next;
  logic [4:0]        w_burst;
  logic              w_space_ok;
  logic              w_avm_read;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_st_valid;
  logic [ADDR_W-1:0] w_base;

  assign w_fs_rise     = r_fs_s2 & ~r_fs_d;
  assign w_fh_rise     = r_fh_s2 & ~r_fh_d;
  assign w_start       = (r_state == S_IDLE) && (w_fs_rise || r_fs_pend);
  assign w_active      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_outstanding = r_issue_cnt - r_ret_cnt;
  assign w_remain      = CNT_W'(FRAME_PIXELS) - r_issue_cnt;
  assign w_burst       = (w_remain >= CNT_W'(BURST_LEN)) ? 5'(BURST_LEN) : 5'(w_remain);
  assign w_issue_next  = r_issue_cnt + CNT_W'(w_burst);
  // Words already buffered plus words still in flight must leave a whole burst of room.
  assign w_space_ok    = (32'(r_fifo_cnt) + 32'(w_outstanding) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
  // A command stalled by waitrequest stays up even after an abort, so the slave never sees it withdrawn.
  assign w_avm_read    = r_cmd_pend || ((r_state == S_ISSUE) && w_space_ok && (w_remain != '0));
  assign w_accept      = w_avm_read && !avm_waitrequest;
  // Late words from an aborted frame or from before the first frame never reach the FIFO.
  assign w_push        = avm_readdatavalid && w_active;
  assign w_st_valid    = (r_fifo_cnt != '0) && (r_state != S_ABORT);
  assign w_pop         = w_st_valid && st_ready;
  assign w_base        = r_front_buf ? BASE_ADDR_1 : BASE_ADDR_0;

  assign avm_read       = w_avm_read;
  assign avm_address    = w_base + (ADDR_W'(r_issue_cnt) << 1);
  assign avm_burstcount = w_burst;
  assign st_data        = r_mem[r_rd_ptr];
  assign st_valid       = w_st_valid;
  assign st_start       = w_st_valid && (r_out_cnt == '0);
  assign st_end         = w_st_valid && (r_out_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign swap_ack       = r_swap_ack;
  assign front_buf      = r_front_buf;
  assign underrun       = r_underrun;

  // Double-flop the controller's asynchronous frame signals and keep one more stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fs_s1 <= 1'b0;
      r_fs_s2 <= 1'b0;
      r_fs_d  <= 1'b0;
      r_fh_s1 <= 1'b0;
      r_fh_s2 <= 1'b0;
      r_fh_d  <= 1'b0;
    end else begin
      r_fs_s1 <= frame_start;
      r_fs_s2 <= r_fs_s1;
      r_fs_d  <= r_fs_s2;
      r_fh_s1 <= frame_hold;
      r_fh_s2 <= r_fh_s1;
      r_fh_d  <= r_fh_s2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection: a frame only leaves ISSUE once its final burst has been accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_fh_rise) w_state_nxt = S_ABORT;
        else if (w_accept && (w_issue_next == CNT_W'(FRAME_PIXELS))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_fh_rise) w_state_nxt = S_ABORT;
        else if (r_out_cnt == CNT_W'(FRAME_PIXELS)) w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        if (!w_avm_read && (w_outstanding == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame bookkeeping: issue/return/output counters, buffer swap, pending start and underrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_out_cnt   <= '0;
      r_cmd_pend  <= 1'b0;
      r_fs_pend   <= 1'b0;
      r_front_buf <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      r_cmd_pend <= w_avm_read && avm_waitrequest;
      if (w_start) begin
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
        r_out_cnt   <= '0;
        r_underrun  <= 1'b0;
        r_fs_pend   <= 1'b0;
        if (swap_req) begin
          r_front_buf <= ~r_front_buf;
          r_swap_ack  <= 1'b1;
        end
      end else begin
        if (w_fs_rise && (r_state != S_IDLE)) r_fs_pend <= 1'b1;
        if (w_accept) r_issue_cnt <= w_issue_next;
        if (avm_readdatavalid && (r_state != S_IDLE)) r_ret_cnt <= r_ret_cnt + 1'b1;
        if (w_pop) r_out_cnt <= r_out_cnt + 1'b1;
        if (st_ready && (r_fifo_cnt == '0) && w_active && (r_out_cnt < CNT_W'(FRAME_PIXELS)))
          r_underrun <= 1'b1;
      end
    end
  end

  // Show-ahead FIFO pointers; ABORT holds the FIFO flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (r_state == S_ABORT) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fifo_cnt <= r_fifo_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // FIFO storage, written with each returned word.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= avm_readdata;
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader
module tb_vga_frame_reader;

  localparam int FP = 200;
  localparam int BL = 16;
  localparam int FD = 64;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0009_6000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start, frame_hold;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [4:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [15:0] st_data;
  logic        st_valid, st_ready, st_start, st_end;
  logic        swap_req, swap_ack, front_buf, underrun;

  vga_frame_reader #(
    .FRAME_PIXELS(FP),
    .BURST_LEN(BL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .frame_hold(frame_hold),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_start(st_start), .st_end(st_end),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  int ready_pct = 100, wr_pct = 0, wr_left = 0, lat_min = 0, lat_max = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  int last_due = 0;
  int k = 0, j = 0, occ = 0, max_occ = 0;
  int first_px_cyc = 0, last_px_cyc = 0, first_rd_cyc = 0;
  bit aborting = 0, ack_ok = 0;
  int hold_cnt = 0;
  logic exp_fb = 1'b0;
  logic [31:0] base_exp = BASE0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int b);
    return base_exp + 32'(2 * BL * b);
  endfunction

  function automatic logic [31:0] exp_bc(input int b);
    return ((FP - BL * b) < BL) ? 32'(FP - BL * b) : 32'(BL);
  endfunction

  // One clock: drive inputs after the edge, then observe what the next edge will commit.
  task automatic tick();
    logic [31:0] a;
    int d;
    @(posedge clk);
    #1;
    cyc++;
    st_ready        = ($urandom_range(0, 99) < ready_pct);
    avm_waitrequest = (wr_left > 0) || ($urandom_range(0, 99) < wr_pct);
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      a = q_addr.pop_front();
      d = q_due.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = a[16:1];
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'($urandom);
    end
    #1;
    if (!reset_n) return;
    if (avm_read && avm_waitrequest) begin
      chk("hold_addr", avm_address, exp_addr(j));
      chk("hold_bcnt", 32'(avm_burstcount), exp_bc(j));
    end
    if (avm_read && wr_left > 0) wr_left--;
    if (avm_read && !avm_waitrequest) begin
      chk("cmd_addr", avm_address, exp_addr(j));
      chk("cmd_bcnt", 32'(avm_burstcount), exp_bc(j));
      for (int w = 0; w < int'(avm_burstcount); w++) begin
        d = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        q_addr.push_back(avm_address + 32'(2 * w));
        q_due.push_back(d);
      end
      j++;
    end
    if (!aborting) begin
      occ = occ + int'(avm_readdatavalid) - int'(st_valid && st_ready);
      if (occ > max_occ) max_occ = occ;
    end
    if (st_valid && st_ready) begin
      if (k == 0) first_px_cyc = cyc;
      last_px_cyc = cyc;
      chk("px_data", 32'(st_data), ((base_exp >> 1) + 32'(k)) & 32'h0000_FFFF);
      chk("px_start", 32'(st_start), 32'(k == 0));
      chk("px_end", 32'(st_end), 32'(k == FP - 1));
      k++;
    end
    if (swap_ack && !ack_ok) chk("swap_ack_spurious", 32'(swap_ack), 0);
    if (aborting) begin
      hold_cnt++;
      if (hold_cnt >= 3) begin
        chk("abort_valid", 32'(st_valid), 0);
        chk("abort_read", 32'(avm_read), 0);
      end
    end
  endtask

  task automatic start_frame(input bit exp_swap);
    if (exp_swap) exp_fb = ~exp_fb;
    base_exp = exp_fb ? BASE1 : BASE0;
    j = 0; k = 0; occ = 0; max_occ = 0; last_due = cyc; aborting = 0; hold_cnt = 0;
    frame_start = 1'b1;
    tick();
    chk("pre_read1", 32'(avm_read), 0);
    tick();
    chk("pre_read2", 32'(avm_read), 0);
    ack_ok = 1'b1;
    tick();
    ack_ok = 1'b0;
    first_rd_cyc = cyc;
    chk("first_read", 32'(avm_read), 1);
    chk("first_addr", avm_address, base_exp);
    chk("first_bcnt", 32'(avm_burstcount), exp_bc(0));
    chk("swap_ack", 32'(swap_ack), 32'(exp_swap));
    chk("front_buf", 32'(front_buf), 32'(exp_fb));
    chk("underrun_clr", 32'(underrun), 0);
    frame_start = 1'b0;
  endtask

  task automatic wait_px(input int n);
    int t = 0;
    while (k < n && t < 20000) begin
      tick();
      t++;
    end
    chk("wait_px", 32'(k >= n), 1);
  endtask

  task automatic wait_frame(input string tag);
    wait_px(FP);
    repeat (4) tick();
    chk({tag, "_count"}, 32'(k), 32'(FP));
    chk({tag, "_idle_valid"}, 32'(st_valid), 0);
    chk({tag, "_bursts"}, 32'(j), 32'((FP + BL - 1) / BL));
    chk({tag, "_fifo_bound"}, 32'(max_occ <= FD), 1);
  endtask

  initial begin
    int t;
    reset_n = 1'b0; frame_start = 1'b0; frame_hold = 1'b0; swap_req = 1'b0;
    st_ready = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;

    repeat (3) tick();
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_valid", 32'(st_valid), 0);
    chk("rst_start", 32'(st_start), 0);
    chk("rst_end", 32'(st_end), 0);
    chk("rst_swap_ack", 32'(swap_ack), 0);
    chk("rst_front_buf", 32'(front_buf), 0);
    chk("rst_underrun", 32'(underrun), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Frame 1: zero-wait slave, sink always ready.
    start_frame(1'b0);
    wait_frame("f1");
    chk("first_px_lat", 32'(first_px_cyc - first_rd_cyc), 2);
    chk("throughput", 32'(last_px_cyc - first_px_cyc), 32'(FP - 1));

    // Frame 2: swap into buffer 1, first command stalled 5 clk, random stalls and latency.
    swap_req = 1'b1; wr_left = 5; wr_pct = 20; ready_pct = 70; lat_min = 0; lat_max = 3;
    start_frame(1'b1);
    wait_px(50);  swap_req = 1'b0;
    wait_px(100); swap_req = 1'b1;
    wait_px(150); swap_req = 1'b0;
    wait_frame("f2");
    chk("f2_front_buf", 32'(front_buf), 1);

    // Frame 3: no swap, aborted by frame_hold after 100 pixels.
    wr_pct = 0; ready_pct = 100; lat_min = 30; lat_max = 30;
    start_frame(1'b0);
    wait_px(100);
    frame_hold = 1'b1; aborting = 1'b1; hold_cnt = 0;
    t = 0;
    while ((t < 40 || q_addr.size() > 0) && t < 2000) begin
      tick();
      t++;
    end
    chk("late_words_drained", 32'(q_addr.size()), 0);
    frame_hold = 1'b0;
    repeat (5) tick();

    // Frame 4: restart cleanly at pixel 0 after the abort.
    ready_pct = 70; lat_min = 0; lat_max = 2;
    start_frame(1'b0);
    wait_frame("f4");

    // Frame 5: long slave latency starves the sink.
    ready_pct = 100; lat_min = 200; lat_max = 200;
    start_frame(1'b0);
    wait_frame("f5");
    chk("underrun_set", 32'(underrun), 1);

    // Frame 6: next frame_start clears underrun.
    lat_min = 0; lat_max = 0;
    start_frame(1'b0);
    wait_frame("f6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Frame-buffer read scheduler feeding the VGA output controller's pixel stream sink. Sequences Avalon-MM burst reads of a 640x480 RGB565 frame from SDRAM into an internal FIFO and streams pixels out with start/end-of-packet markers. Aligns each frame to the controller's frame_start/frame_hold signals and manages front/back buffer swapping for the renderer.

## Interface
- ADDR_W, 32, Avalon-MM byte address width
- FRAME_PIXELS, 307200, pixels per frame (640*480)
- BURST_LEN, 16, maximum words per read burst (power of 2, <= FIFO_DEPTH/2)
- FIFO_DEPTH, 64, pixel FIFO depth in words (power of 2)
- BASE_ADDR_0, 32'h0000_0000, byte address of buffer 0
- BASE_ADDR_1, 32'h0009_6000, byte address of buffer 1
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  from the VGA output controller; level high during vsync; asynchronous, double-flopped internally
- frame_hold  in  1  from the VGA output controller; high while the sink clears its FIFO; asynchronous, double-flopped internally
- avm_address  out  ADDR_W  burst start byte address
- avm_read  out  1  read request
- avm_burstcount  out  5  words in burst (1..BURST_LEN)
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  16  returned pixel
- avm_readdatavalid  in  1  returned-word strobe
- st_data  out  16  RGB565 pixel
- st_valid  out  1  pixel valid
- st_ready  in  1  sink ready (sink is in the clk domain)
- st_start  out  1  first pixel of frame
- st_end  out  1  last pixel of frame
- swap_req  in  1  level; renderer has finished the back buffer
- swap_ack  out  1  one-cycle pulse when the swap is taken
- front_buf  out  1  buffer currently scanned out
- underrun  out  1  sticky; sink ready with FIFO empty during an active frame

## Operation
- States: IDLE, ISSUE, DRAIN, ABORT.
- Reset: state IDLE. All outputs 0: avm_read, st_valid, st_start, st_end, swap_ack, front_buf, underrun. FIFO empty. Counters cleared.
- IDLE: waits for a rising edge of synchronized frame_start.
- On that edge:
  - If swap_req is high, front_buf toggles and swap_ack pulses.
  - issue_cnt, ret_cnt and out_cnt are zeroed. underrun clears.
  - State goes to ISSUE.
- ISSUE: starts a burst when free FIFO space minus outstanding words is >= BURST_LEN.
  - avm_burstcount = min(BURST_LEN, FRAME_PIXELS - issue_cnt).
  - avm_address = base(front_buf) + 2*issue_cnt; unsigned, ADDR_W bits, wraps modulo 2^ADDR_W.
  - avm_read, avm_address and avm_burstcount hold stable while avm_waitrequest is high.
  - issue_cnt advances by burstcount on the cycle avm_read=1 and avm_waitrequest=0.
  - When issue_cnt reaches FRAME_PIXELS, state goes to DRAIN.
- Every avm_readdatavalid word is written to the FIFO and increments ret_cnt. The FIFO can never overflow by construction; an overflow is a design error, and the bench asserts on it.
- Stream output:
  - st_valid = FIFO not empty and state is not ABORT.
  - A pixel transfers when st_valid and st_ready are both high; out_cnt then increments.
  - st_start = st_valid and out_cnt==0. st_end = st_valid and out_cnt==FRAME_PIXELS-1.
- DRAIN: goes to IDLE when out_cnt reaches FRAME_PIXELS.
- frame_hold: a synchronized rising edge in ISSUE or DRAIN enters ABORT.
- ABORT:
  - avm_read is deasserted, but only once no command is pending under waitrequest.
  - The FIFO is flushed, and any outstanding readdatavalid words are discarded.
  - State goes to IDLE when outstanding = issue_cnt - ret_cnt reaches 0.
- frame_start edge in a non-IDLE state: latched as pending and serviced on entry to IDLE. A frame is never restarted mid-burst.
- underrun sets when st_ready=1, the FIFO is empty, state is ISSUE or DRAIN, and out_cnt < FRAME_PIXELS.
- swap_req sampled only at the frame_start edge. Changes at any other time have no effect.

## Timing
- Synchronizer latency: 2 clk.
- First avm_read: 3 clk after frame_start rises at the pin (2 sync + 1 edge-detect/state register).
- FIFO is show-ahead. A word written on cycle N appears on st_data with st_valid on cycle N+1.
- Full throughput: one pixel per clk when the slave returns one word per clk.
- swap_ack and front_buf update on the same cycle as the IDLE->ISSUE transition.
- Reset assertion mid-burst immediately returns to the reset state. Late readdatavalid words arriving after reset deassertion are ignored until the first frame_start. The outstanding counter is cleared, and the interconnect is required to be reset together with this block.

## Test plan
- Reset, frame_start pulse, zero-wait slave returning data=address[16:1]:
  - avm_read rises 3 clk later with avm_address=0 and burstcount=16.
  - Exactly 307200 pixels stream out; st_start on pixel 0 (data 0), st_end on pixel 307199 (data 16'hAFFF).
- FRAME_PIXELS=40, BURST_LEN=16: bursts of 16, 16, 8 at addresses 0, 32, 64.
- swap_req=1 before the second frame_start:
  - swap_ack is one pulse and front_buf=1.
  - The first address is 32'h0009_6000. swap_req toggled mid-frame causes no swap.
- avm_waitrequest held high 5 clk: address and burstcount stay stable; issue_cnt is unchanged until it releases.
- frame_hold after 100 pixels with 2 bursts outstanding:
  - st_valid drops within 3 clk.
  - 32 late words are discarded, state returns to IDLE, and the next frame starts at pixel 0 with st_start.
- Slave latency 200 clk with st_ready=1: underrun=1; the next frame_start clears it.
